// File: rtl/contador_display_mux_pkg.sv
// Shared types, 7-segment patterns and the BCD saturation helper for the
// multiplexed BCD counter/display.
package contador_pkg;

  typedef logic [3:0] bcd_t;

  // Bit order {dp,g,f,e,d,c,b,a}, active-high; dp is never lit.
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic bcd_t bcd_sat(input bcd_t n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

endpackage

// File: rtl/contador_display_mux_if.sv
// Control inputs and display/count outputs of contador_display_mux.
// All control inputs are level signals sampled on every rising clk edge; there is no handshake.
interface contador_display_mux_if #(
  parameter int N_DIGITS = 4
);
  logic                    en;
  logic                    up_dn;
  logic                    clear;
  logic                    load;
  logic [4*N_DIGITS-1:0]   load_val;
  logic [7:0]              segments;
  logic [N_DIGITS-1:0]     digit_sel;
  logic [4*N_DIGITS-1:0]   count_bcd;
  logic                    wrap;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  segments, digit_sel, count_bcd, wrap
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output segments, digit_sel, count_bcd, wrap
  );
endinterface

// File: rtl/contador_display_mux_seg7_decoder.sv
// Combinational BCD to 7-segment decoder with a blank override.
module seg7_decoder
  import contador_pkg::*;
(
  input  bcd_t       digit,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/contador_display_mux.sv
// Parametrised BCD up/down counter with time-multiplexed 7-segment drive.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module contador_display_mux
  import contador_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int TICK_DIV    = 1000,
  parameter int REFRESH_DIV = 250,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  contador_display_mux_if.slave bus
);

  localparam int PSC_W = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS    > 1) ? $clog2(N_DIGITS)    : 1;

  localparam logic [7:0]          SEG_RST = SEG_ACT_LOW ? ~SEG_0 : SEG_0;
  localparam logic [N_DIGITS-1:0] SEL_ONE = N_DIGITS'(1);
  localparam logic [N_DIGITS-1:0] SEL_RST = SEG_ACT_LOW ? ~SEL_ONE : SEL_ONE;

  logic [PSC_W-1:0]           psc_q, psc_d;
  bcd_t [N_DIGITS-1:0]        count_q, count_d;
  logic                       wrap_q, wrap_d;
  logic [REF_W-1:0]           ref_q, ref_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 seg_q, seg_d;
  logic [N_DIGITS-1:0]        sel_q, sel_d;

  logic                       tick;
  logic                       carry, borrow;
  bcd_t [N_DIGITS-1:0]        up_val, dn_val;
  bcd_t                       mux_digit;
  logic                       mux_blank;
  logic [7:0]                 dec_seg;

  // Prescaler and counter chain; carry/borrow ripple across all digits in one cycle.
  always_comb begin
    tick  = (psc_q == PSC_W'(TICK_DIV - 1));
    psc_d = tick ? '0 : psc_q + PSC_W'(1);

    up_val = count_q;
    carry  = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (count_q[i] == 4'd9) begin
          up_val[i] = 4'd0;
        end else begin
          up_val[i] = count_q[i] + 4'd1;
          carry     = 1'b0;
        end
      end
    end

    dn_val = count_q;
    borrow = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (borrow) begin
        if (count_q[i] == 4'd0) begin
          dn_val[i] = 4'd9;
        end else begin
          dn_val[i] = count_q[i] - 4'd1;
          borrow    = 1'b0;
        end
      end
    end

    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
      psc_d   = '0;
    end else if (bus.load) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        count_d[i] = bcd_sat(bus.load_val[4*i +: 4]);
      end
    end else if (tick && bus.en) begin
      count_d = bus.up_dn ? up_val : dn_val;
      wrap_d  = bus.up_dn ? carry : borrow;
    end
  end

  // Scan: the output registers take the digit selected by the next scan index,
  // so digit_sel and segments always change together.
  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    mux_digit = count_q[idx_d];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] upper_zero;
  logic                zero_acc;

  always_comb begin
    zero_acc = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc && (count_q[i] == 4'd0);
      upper_zero[i] = zero_acc;
    end
    mux_blank = (idx_d != '0) && upper_zero[idx_d];
  end
`else
  assign mux_blank = 1'b0;
`endif

  seg7_decoder u_dec (
    .digit (mux_digit),
    .blank (mux_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    seg_d = SEG_ACT_LOW ? ~dec_seg : dec_seg;
    sel_d = SEG_ACT_LOW ? ~(SEL_ONE << idx_d) : (SEL_ONE << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_RST;
      sel_q   <= SEL_RST;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.segments  = seg_q;
  assign bus.digit_sel = sel_q;

endmodule

// File: tb/tb_contador_display_mux.sv
// Self-checking bench for contador_display_mux: directed scenarios plus randomized
// traffic against an integer-arithmetic reference model.
module tb_contador_display_mux;

  localparam int N    = 4;
  localparam int TD   = 3;
  localparam int RD   = 4;
  localparam int MAXV = 9999;
  localparam logic [7:0] SEG_TBL [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                          8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  contador_display_mux_if #(.N_DIGITS(N)) intf ();

  contador_display_mux #(
    .N_DIGITS(N), .TICK_DIV(TD), .REFRESH_DIV(RD), .SEG_ACT_LOW(1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  // ---------------- reference model ----------------
  int         m_cnt = 0;
  int         m_psc = 0;
  int         m_ref = 0;
  int         m_idx = 0;
  logic       m_wrap = 1'b0;
  logic [7:0] m_seg = 8'h3F;
  logic [3:0] m_sel = 4'b0001;

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int sat_value(input logic [15:0] lv);
    int v = 0;
    for (int i = 0; i < N; i++) begin
      int d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * pow10(i);
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int pos);
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && v < pow10(pos)) return 8'h00;
`endif
    return SEG_TBL[(v / pow10(pos)) % 10];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int  old_cnt;
    bit  tk;
    if (!rst_n) begin
      m_cnt = 0; m_psc = 0; m_ref = 0; m_idx = 0;
      m_wrap = 1'b0; m_seg = 8'h3F; m_sel = 4'b0001;
    end else begin
      old_cnt = m_cnt;
      tk = (m_psc == TD - 1);
      if (m_ref == RD - 1) begin
        m_ref = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_ref = m_ref + 1;
      end
      m_sel = 4'(1 << m_idx);
      m_seg = exp_seg(old_cnt, m_idx);
      m_wrap = 1'b0;
      if (intf.clear) begin
        m_cnt = 0;
        m_psc = 0;
      end else begin
        m_psc = tk ? 0 : m_psc + 1;
        if (intf.load) begin
          m_cnt = sat_value(intf.load_val);
        end else if (tk && intf.en) begin
          if (intf.up_dn) begin
            m_wrap = (old_cnt == MAXV);
            m_cnt  = (old_cnt + 1) % (MAXV + 1);
          end else begin
            m_wrap = (old_cnt == 0);
            m_cnt  = (old_cnt == 0) ? MAXV : old_cnt - 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input logic e,
                       input logic u, input logic [15:0] lv);
    intf.clear    = c;
    intf.load     = l;
    intf.en       = e;
    intf.up_dn    = u;
    intf.load_val = lv;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++; if (intf.count_bcd !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h exp=0000", intf.count_bcd); end
    checks++; if (intf.digit_sel !== 4'b0001) begin errors++; $display("FAIL reset_sel got=%b exp=0001", intf.digit_sel); end
    checks++; if (intf.segments !== 8'h3F) begin errors++; $display("FAIL reset_seg got=%h exp=3f", intf.segments); end
    checks++; if (intf.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", intf.wrap); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    int wraps = 0;
    bit seen_max = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
    cyc();
    checks++; if (intf.count_bcd !== 16'h9998) begin errors++; $display("FAIL up_load got=%h exp=9998", intf.count_bcd); end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    for (int k = 0; k < 2*TD; k++) begin
      cyc();
      if (intf.wrap === 1'b1) wraps++;
      if (intf.count_bcd === 16'h9999) seen_max = 1;
      checks++; if (intf.count_bcd !== to_bcd(m_cnt) || intf.wrap !== m_wrap) begin
        errors++; $display("FAIL up_step got=%h/%b exp=%h/%b", intf.count_bcd, intf.wrap, to_bcd(m_cnt), m_wrap);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    checks++; if (intf.count_bcd !== 16'h0000) begin errors++; $display("FAIL up_wrap_value got=%h exp=0000", intf.count_bcd); end
    checks++; if (wraps != 1) begin errors++; $display("FAIL up_wrap_pulses got=%0d exp=1", wraps); end
    checks++; if (!seen_max) begin errors++; $display("FAIL up_pass_9999 got=0 exp=1"); end
    cyc();
    checks++; if (intf.wrap !== 1'b0) begin errors++; $display("FAIL up_wrap_drop got=%b exp=0", intf.wrap); end
  endtask

  task automatic test_down_wrap();
    int wraps = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < TD; k++) begin
      cyc();
      if (intf.wrap === 1'b1) wraps++;
    end
    checks++; if (intf.count_bcd !== 16'h9999) begin errors++; $display("FAIL down_wrap_value got=%h exp=9999", intf.count_bcd); end
    checks++; if (wraps != 1) begin errors++; $display("FAIL down_wrap_pulses got=%0d exp=1", wraps); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    wraps = 0;
    for (int k = 0; k < TD; k++) begin
      cyc();
      if (intf.wrap === 1'b1) wraps++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checks++; if (intf.count_bcd !== 16'h0009) begin errors++; $display("FAIL down_borrow got=%h exp=0009", intf.count_bcd); end
    checks++; if (wraps != 0) begin errors++; $display("FAIL down_borrow_wrap got=%0d exp=0", wraps); end
  endtask

  task automatic test_priority();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0777);
    cyc();
    // Held for a full prescaler period so a tick coincides with clear+load.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    for (int k = 0; k < TD; k++) begin
      cyc();
      checks++; if (intf.count_bcd !== 16'h0000 || intf.wrap !== 1'b0) begin
        errors++; $display("FAIL prio_clear got=%h/%b exp=0000/0", intf.count_bcd, intf.wrap);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hA5F3);
    cyc();
    checks++; if (intf.count_bcd !== 16'h9593) begin errors++; $display("FAIL prio_load_sat got=%h exp=9593", intf.count_bcd); end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    for (int k = 0; k < 2*TD; k++) begin
      cyc();
      checks++; if (intf.count_bcd !== to_bcd(m_cnt)) begin
        errors++; $display("FAIL prio_after got=%h exp=%h", intf.count_bcd, to_bcd(m_cnt));
      end
    end
  endtask

  task automatic test_en_low();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0500);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int k = 0; k < 3*TD; k++) begin
      cyc();
      intf.up_dn = 1'($urandom_range(0, 1));
      checks++; if (intf.count_bcd !== 16'h0500) begin errors++; $display("FAIL en_low_hold got=%h exp=0500", intf.count_bcd); end
    end
  endtask

  task automatic test_scan();
    logic [3:0] last_sel;
    int         run;
    logic [7:0] want;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc();
    last_sel = intf.digit_sel;
    run = 0;
    for (int k = 0; k < 5*RD; k++) begin
      cyc();
      case (intf.digit_sel)
        4'b0001: want = 8'h66;
        4'b0010: want = 8'h4F;
        4'b0100: want = 8'h5B;
        4'b1000: want = 8'h06;
        default: want = 8'hxx;
      endcase
      checks++; if (intf.segments !== want || intf.digit_sel !== m_sel) begin
        errors++; $display("FAIL scan_1234 sel=%b seg=%h exp_sel=%b exp_seg=%h", intf.digit_sel, intf.segments, m_sel, want);
      end
      if (intf.digit_sel !== last_sel) begin
        if (run != 0) begin
          checks++; if (run != RD) begin errors++; $display("FAIL scan_hold got=%0d exp=%0d", run, RD); end
        end
        run = 1;
        last_sel = intf.digit_sel;
      end else if (run != 0) begin
        run++;
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] want;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0042);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc();
    for (int k = 0; k < N*RD; k++) begin
      cyc();
      case (intf.digit_sel)
        4'b0001: want = 8'h5B;
        4'b0010: want = 8'h66;
`ifdef LEADING_ZERO_BLANK_EN
        default: want = 8'h00;
`else
        default: want = 8'h3F;
`endif
      endcase
      checks++; if (intf.segments !== want) begin errors++; $display("FAIL lz_0042 sel=%b got=%h exp=%h", intf.digit_sel, intf.segments, want); end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc();
    for (int k = 0; k < N*RD; k++) begin
      cyc();
`ifdef LEADING_ZERO_BLANK_EN
      want = (intf.digit_sel == 4'b0001) ? 8'h3F : 8'h00;
`else
      want = 8'h3F;
`endif
      checks++; if (intf.segments !== want) begin errors++; $display("FAIL lz_0000 sel=%b got=%h exp=%h", intf.digit_sel, intf.segments, want); end
    end
  endtask

  task automatic test_random();
    logic [15:0] lv;
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0: lv = 16'h9998;
        1: lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
      drive(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), lv);
      cyc();
      checks++; if (intf.count_bcd !== to_bcd(m_cnt) || intf.wrap !== m_wrap ||
                    intf.digit_sel !== m_sel || intf.segments !== m_seg) begin
        errors++;
        $display("FAIL random cyc=%0d got cnt=%h wrap=%b sel=%b seg=%h exp cnt=%h wrap=%b sel=%b seg=%h",
                 k, intf.count_bcd, intf.wrap, intf.digit_sel, intf.segments,
                 to_bcd(m_cnt), m_wrap, m_sel, m_seg);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h4321);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    repeat (RD + 1) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (intf.count_bcd !== 16'h0000 || intf.digit_sel !== 4'b0001 ||
                  intf.segments !== 8'h3F || intf.wrap !== 1'b0) begin
      errors++; $display("FAIL async_reset got cnt=%h sel=%b seg=%h wrap=%b", intf.count_bcd, intf.digit_sel, intf.segments, intf.wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2*RD; k++) begin
      cyc();
      checks++; if (intf.count_bcd !== to_bcd(m_cnt) || intf.digit_sel !== m_sel || intf.segments !== m_seg) begin
        errors++; $display("FAIL post_reset got cnt=%h sel=%b seg=%h exp cnt=%h sel=%b seg=%h",
                           intf.count_bcd, intf.digit_sel, intf.segments, to_bcd(m_cnt), m_sel, m_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_en_low();
    test_scan();
    test_leading_zero();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
